// File: rtl/wb_gpio_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the GPIO/PWM/timer slave.
// Define WB_GPIO_ARB_TIMEOUT_EN to add the stuck-slave watchdog.
module wb_gpio_arbiter #(
  parameter int WB_DAT_WIDTH   = 16,
  parameter int WB_ADR_WIDTH   = 14,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WB_ADR_WIDTH-1:0] m0_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] m0_dat_i,
  input  logic                    m0_we_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  output logic [WB_DAT_WIDTH-1:0] m0_dat_o,
  output logic                    m0_ack_o,
  input  logic [WB_ADR_WIDTH-1:0] m1_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] m1_dat_i,
  input  logic                    m1_we_i,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  output logic [WB_DAT_WIDTH-1:0] m1_dat_o,
  output logic                    m1_ack_o,
  output logic [WB_ADR_WIDTH-1:0] s_adr_o,
  output logic [WB_DAT_WIDTH-1:0] s_dat_o,
  output logic                    s_we_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  input  logic [WB_DAT_WIDTH-1:0] s_dat_i,
  input  logic                    s_ack_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  logic [1:0]              r_state;
  logic [1:0]              w_next;
  logic                    r_last;
  logic                    w_last_next;
  logic                    w_req0;
  logic                    w_req1;
  logic                    w_idle;
  logic                    w_gnt;
  logic                    w_sel;
  logic                    w_cyc;
  logic                    w_stb;
  logic                    w_to;
  logic                    w_done;
  logic                    w_ack;
  logic [WB_DAT_WIDTH-1:0] w_rdat;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;
  assign w_idle = (r_state == IDLE);
  assign w_gnt  = |r_state;
  assign w_sel  = r_state[1];
  assign w_cyc  = w_sel ? m1_cyc_i : m0_cyc_i;
  assign w_stb  = w_sel ? m1_stb_i : m0_stb_i;

`ifdef WB_GPIO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_to;

  assign w_to = w_gnt & ~s_ack_i
              & (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_cnt <= w_gnt ? r_cnt + 1'b1 : '0;
      if (w_to) r_to <= 1'b1;
    end
  end

  assign timeout_o = r_to;
`else
  assign w_to      = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign w_done = w_gnt & (s_ack_i | ~w_cyc | w_to);

  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    unique case (1'b1)
      w_idle & w_req0 & (~w_req1 | r_last): w_next = GRANT0;
      w_idle & w_req1 & (~w_req0 | ~r_last): w_next = GRANT1;
      w_done: begin
        w_next      = IDLE;
        w_last_next = w_sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (w_gnt) begin
      s_adr_o = w_sel ? m1_adr_i : m0_adr_i;
      s_dat_o = w_sel ? m1_dat_i : m0_dat_i;
      s_we_o  = w_sel ? m1_we_i : m0_we_i;
      s_cyc_o = w_cyc & ~w_to;
      s_stb_o = w_stb & ~w_to;
    end
  end

  // A watchdog expiry looks like an ack carrying all-ones.
  assign w_ack  = s_ack_i | w_to;
  assign w_rdat = w_to ? '1 : s_dat_i;

  assign m0_ack_o = r_state[0] & w_ack;
  assign m1_ack_o = r_state[1] & w_ack;
  assign m0_dat_o = r_state[0] ? w_rdat : '0;
  assign m1_dat_o = r_state[1] ? w_rdat : '0;
  assign grant_o  = r_state;

endmodule

// File: tb/tb_wb_gpio_arbiter.sv
// Directed bench for wb_gpio_arbiter.
// Watchdog steps run when WB_GPIO_ARB_TIMEOUT_EN is defined.
module tb_wb_gpio_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [15:0] m0_dat_i, m1_dat_i, s_dat_o;
  logic [15:0] m0_dat_o, m1_dat_o, s_dat_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int n_cmp = 0;
  int n_err = 0;
  int n0;
  int n1;

  wb_gpio_arbiter #(
    .WB_DAT_WIDTH  (16),
    .WB_ADR_WIDTH  (14),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_we_i  (m0_we_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_we_i  (m1_we_i),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 0;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 0; m1_stb_i = 0;
    s_ack_i = 1; s_dat_i = 16'hFFFF;

    // reset: request and ack present, nothing may leak
    tick;
    chk("rst_grant", grant_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_ack0", m0_ack_o, 0);
    chk("rst_dat0", m0_dat_o, 0);
    chk("rst_to", timeout_o, 0);
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0; s_dat_i = 0;
    rst = 1'b0;

    // single master 0 write
    m0_adr_i = 14'h0001; m0_dat_i = 16'hA5A5; m0_we_i = 1;
    m0_cyc_i = 1; m0_stb_i = 1;
    #1;
    chk("t1_stb_early", s_stb_o, 0);
    tick;
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_stb", s_stb_o, 1);
    chk("t1_adr", s_adr_o, 14'h0001);
    chk("t1_dat", s_dat_o, 16'hA5A5);
    chk("t1_we", s_we_o, 1);
    chk("t1_noack", m0_ack_o, 0);
    s_ack_i = 1;
    #1;
    chk("t1_ack0", m0_ack_o, 1);
    chk("t1_ack1", m1_ack_o, 0);
    tick;
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    #1;
    chk("t1_idle", grant_o, 0);

    // tie just after reset: master 0 first
    rst = 1; #1; rst = 0;
    m0_adr_i = 14'h0002; m1_adr_i = 14'h0010;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick;
    chk("t2_grant0", grant_o, 2'b01);
    chk("t2_adr0", s_adr_o, 14'h0002);
    s_ack_i = 1; s_dat_i = 16'h5555;
    #1;
    chk("t2_rd0", m0_dat_o, 16'h5555);
    chk("t2_ack1_lo", m1_ack_o, 0);
    chk("t2_dat1_lo", m1_dat_o, 0);
    tick;
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk("t2_bubble", grant_o, 0);
    chk("t2_bub_stb", s_stb_o, 0);
    tick;
    chk("t2_grant1", grant_o, 2'b10);
    chk("t2_adr1", s_adr_o, 14'h0010);
    s_ack_i = 1; s_dat_i = 16'h1234;
    #1;
    chk("t2_ack1", m1_ack_o, 1);
    chk("t2_rd1", m1_dat_o, 16'h1234);
    chk("t2_ack0_lo", m0_ack_o, 0);
    chk("t2_dat0_lo", m0_dat_o, 0);
    tick;
    s_ack_i = 0;

    // continuous requests: alternate 0,1,0,1...
    m0_cyc_i = 1; m0_stb_i = 1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("t3_grant%0d", i), grant_o,
          (i % 2 == 0) ? 2'b01 : 2'b10);
      s_ack_i = 1;
      #1;
      n0 += int'(m0_ack_o);
      n1 += int'(m1_ack_o);
      tick;
      s_ack_i = 0;
    end
    chk("t3_acks0", n0, 4);
    chk("t3_acks1", n1, 4);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;

    // master 1 aborts with master 0 pending
    m1_cyc_i = 1; m1_stb_i = 1;
    tick;
    chk("t4_grant1", grant_o, 2'b10);
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 0;
    #1;
    chk("t4_noack", m1_ack_o, 0);
    chk("t4_cyc", s_cyc_o, 0);
    tick;
    chk("t4_idle", grant_o, 0);
    chk("t4_noack2", m1_ack_o, 0);
    tick;
    chk("t4_grant0", grant_o, 2'b01);
    chk("t4_cyc0", s_cyc_o, 1);

    // async reset inside GRANT0
    s_ack_i = 1; rst = 1;
    #1;
    chk("t5_grant", grant_o, 0);
    chk("t5_stb", s_stb_o, 0);
    chk("t5_cyc", s_cyc_o, 0);
    chk("t5_ack0", m0_ack_o, 0);
    chk("t5_ack1", m1_ack_o, 0);
    s_ack_i = 0; rst = 0; m1_cyc_i = 1;
    tick;
    chk("t5_tie0", grant_o, 2'b01);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0;
    tick;
    chk("t5_abort", grant_o, 0);
    tick;
    chk("t5_stb_nocyc", grant_o, 0);
    m1_stb_i = 0;

    // stuck slave
    m0_cyc_i = 1; m0_stb_i = 1;
    tick;
    chk("t6_grant0", grant_o, 2'b01);
    chk("t6_noack", m0_ack_o, 0);
    m1_cyc_i = 1; m1_stb_i = 1;
`ifdef WB_GPIO_ARB_TIMEOUT_EN
    repeat (6) begin
      tick;
      chk("t6_wait", m0_ack_o, 0);
    end
    tick;
    chk("t6_to_ack", m0_ack_o, 1);
    chk("t6_to_dat", m0_dat_o, 16'hFFFF);
    chk("t6_to_stb", s_stb_o, 0);
    chk("t6_to_cyc", s_cyc_o, 0);
    chk("t6_to_flag0", timeout_o, 0);
    tick;
    chk("t6_to_flag1", timeout_o, 1);
    chk("t6_to_idle", grant_o, 0);
    chk("t6_to_ackoff", m0_ack_o, 0);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick;
    chk("t6_next1", grant_o, 2'b10);
    s_ack_i = 1;
    #1;
    chk("t6_ack1", m1_ack_o, 1);
    tick;
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    #1;
    chk("t6_sticky", timeout_o, 1);
`else
    repeat (10) tick;
    chk("t6_held", grant_o, 2'b01);
    chk("t6_held_ack", m0_ack_o, 0);
    chk("t6_no_to", timeout_o, 0);
    s_ack_i = 1;
    #1;
    chk("t6_late_ack", m0_ack_o, 1);
    tick;
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk("t6_idle", grant_o, 0);
    tick;
    chk("t6_next1", grant_o, 2'b10);
    s_ack_i = 1;
    tick;
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_gpio_arbiter.md
Name: wb_gpio_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter that shares the GPIO/PWM/timer register slave between requesters.
- Master 0 is the host SPI-to-Wishbone bridge; master 1 is an on-chip sequencer, e.g. a servo/PWM ramp engine.
- Round-robin grant, held for the whole cycle until the slave acks, with an optional watchdog for a stuck slave.
- Sits between the bus masters and the GPIO register slave in the core's Wishbone fabric.

Parameters:
- WB_DAT_WIDTH, 16, data bus width.
- WB_ADR_WIDTH, 14, address bus width.
- TIMEOUT_CYCLES, 64, watchdog limit in clk cycles after grant; used only with the optional feature; must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- m0_adr_i  in  WB_ADR_WIDTH  master 0 address
- m0_dat_i  in  WB_DAT_WIDTH  master 0 write data
- m0_we_i  in  1  master 0 write enable
- m0_cyc_i  in  1  master 0 cycle
- m0_stb_i  in  1  master 0 strobe
- m0_dat_o  out  WB_DAT_WIDTH  master 0 read data
- m0_ack_o  out  1  master 0 acknowledge
- m1_*  same seven ports as master 0, for master 1
- s_adr_o  out  WB_ADR_WIDTH  slave address
- s_dat_o  out  WB_DAT_WIDTH  slave write data
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_dat_i  in  WB_DAT_WIDTH  slave read data
- s_ack_i  in  1  slave acknowledge
- grant_o  out  2  one-hot current grant; 00 = idle
- timeout_o  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. While rst is high:
  - FSM is in IDLE; last_grant = 1, so master 0 wins the first tie.
  - grant_o = 00; all s_* outputs are 0; m0_ack_o = m1_ack_o = 0; m*_dat_o = 0; timeout_o = 0.
- Request definitions: req0 = m0_cyc_i & m0_stb_i; req1 = m1_cyc_i & m1_stb_i.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - req0 only -> GRANT0. req1 only -> GRANT1.
  - Both requesting -> grant the master that is not last_grant.
  - No requests -> stay in IDLE.
  - The grant register updates on the clock edge; grant_o is registered.
- GRANTn, slave outputs:
  - s_adr_o, s_dat_o, s_we_o, s_cyc_o and s_stb_o are combinationally muxed from master n.
  - The other master's signals are ignored.
- GRANTn, return path:
  - mn_ack_o = s_ack_i and mn_dat_o = s_dat_i, both combinational.
  - The non-granted master sees ack = 0 and dat = 0.
- GRANTn exit on s_ack_i = 1: next state is IDLE and last_grant <= n. This gives a one-cycle bubble between grants.
- GRANTn exit on master abort: if mn_cyc_i falls before any ack, next state is IDLE, last_grant <= n, and no ack is issued.
- Stb without cyc: a master holding stb with cyc = 0 is not a request.
- Fairness: with continuous requests from both masters, grants alternate 0,1,0,1. Worst-case wait is one full slave transaction plus 2 cycles.
- Latency:
  - Request with arbiter idle -> s_stb_o asserted the next cycle.
  - Slave ack -> master ack in the same cycle.
- No bursts: the grant is released after every ack, including when cyc is held for back-to-back transfers. The master must deassert stb for at least one cycle or accept re-arbitration.
- Reset mid-transaction: all outputs go to 0 immediately (asynchronous). The slave cycle is abandoned and no ack is passed to either master.
- Simultaneous s_ack_i and master cyc drop in the same cycle: the ack is forwarded and the state goes to IDLE.

Optional Feature:
- Macro: WB_GPIO_ARB_TIMEOUT_EN.
- When defined, a watchdog counter runs during GRANTn:
  - The counter is zeroed when the FSM enters GRANTn and increments each cycle in GRANTn.
  - On the cycle the counter equals TIMEOUT_CYCLES-1 with no s_ack_i: mn_ack_o is asserted for one cycle with mn_dat_o = all-ones.
  - The same cycle forces s_cyc_o = s_stb_o = 0.
  - Next state is IDLE; last_grant <= n; timeout_o is set.
  - timeout_o clears only on rst.
- When not defined: there is no counter, timeout_o is tied to 0, and a stuck slave holds the grant indefinitely.

Test Plan:
- Single master 0 write, adr 0x0001, dat 0xA5A5, slave acks 1 cycle after stb -> s_stb_o high 1 cycle after request; s_adr_o = 0x0001, s_dat_o = 0xA5A5; m0_ack_o in the same cycle as s_ack_i; grant_o 01 -> 00.
- Both masters request the same cycle just after reset -> master 0 granted first, then master 1 after a one-cycle IDLE bubble; m1 reads 0x1234 returned by the slave.
- Both masters request continuously for 8 transactions -> grant_o sequence is 01,10,01,10,... and each master receives exactly 4 acks.
- Master 1 granted, then drops cyc before the slave acks -> no m1_ack_o; FSM returns to IDLE next cycle; pending m0 request granted 1 cycle later.
- Assert rst while GRANT0 is mid-transaction -> all s_* outputs, acks and grant_o are 0 immediately; after release, the first tie goes to master 0.
- With WB_GPIO_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never acks -> m0_ack_o pulses on the 8th grant cycle with m0_dat_o = 0xFFFF; timeout_o = 1 and stays set; master 1 is served next.
